// File: rtl/pl_adc_pkg.sv
// rtl/pl_adc_pkg.sv - shared types and constants for the ADC stream capture block
//
// Contents:
//   DEF_*      default widths used as parameter defaults by the capture block
//   state_e    capture FSM states
//   MODE_*     sample source selection codes carried on i_Mode

package pl_adc_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_CNT_W  = 20;
    localparam int DEF_DEC_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_LIVE     = 2'd0;
    localparam logic [1:0] MODE_COUNT    = 2'd1;
    localparam logic [1:0] MODE_FIXED    = 2'd2;
    localparam logic [1:0] MODE_LIVE_ALT = 2'd3;

endpackage

// File: rtl/pl_adc_decimator.sv
// rtl/pl_adc_decimator.sv - sample-slot strobe generator keeping 1 of every decim_i+1 cycles
//
// Ports:
//   clk_i      capture clock, rising edge
//   rst_ni     synchronous active-low reset
//   clear_i    restart the phase counter (frame start)
//   run_i      counter advances only while high
//   decim_i    latched decimation ratio minus one
//   slot_o     high on the cycles a sample should be taken

module pl_adc_decimator #(
    parameter int DEC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic [DEC_W-1:0] decim_i,
    output logic             slot_o
);

    logic [DEC_W-1:0] cnt_q;
    logic [DEC_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == decim_i) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase zero is the slot, so the first RUN cycle after a start always samples.
    assign slot_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/pl_adc_stream_capture.sv
// rtl/pl_adc_stream_capture.sv - frame capture from parallel CMOS ADC to a valid/ready stream
//
// Ports:
//   i_CMOS_Clk     ADC data clock, all logic on its rising edge
//   i_Rst_n        synchronous active-low reset
//   i_CMOS_Data    raw ADC sample, registered every cycle
//   i_ADC_Work     level request: start a frame / acknowledge done
//   i_Mode         sample source: live, counter pattern, fixed pattern
//   i_Num_Samples  beats per frame, latched at start
//   i_Decim        keep 1 of every i_Decim+1 samples, latched at start
//   o_Data         stream data (sample zero-extended)
//   o_Valid        stream valid
//   i_Ready        stream ready
//   o_Last         marks the final beat of a completed frame
//   o_ADC_Done     frame complete, held until i_ADC_Work drops
//   o_Busy         high in RUN and DRAIN
//   o_Overrun      sticky: a sample was dropped due to backpressure
//   o_Beat_Count   beats delivered in the current/last frame

module pl_adc_stream_capture
    import pl_adc_pkg::*;
#(
    parameter int                DATA_W        = DEF_DATA_W,
    parameter int                OUT_W         = DEF_OUT_W,
    parameter int                CNT_W         = DEF_CNT_W,
    parameter int                DEC_W         = DEF_DEC_W,
    parameter logic [DATA_W-1:0] FIXED_PATTERN = 12'h929
) (
    input  logic              i_CMOS_Clk,
    input  logic              i_Rst_n,
    input  logic [DATA_W-1:0] i_CMOS_Data,
    input  logic              i_ADC_Work,
    input  logic [1:0]        i_Mode,
    input  logic [CNT_W-1:0]  i_Num_Samples,
    input  logic [DEC_W-1:0]  i_Decim,
    output logic [OUT_W-1:0]  o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Last,
    output logic              o_ADC_Done,
    output logic              o_Busy,
    output logic              o_Overrun,
    output logic [CNT_W-1:0]  o_Beat_Count
);

    state_e            state_q;
    logic [DATA_W-1:0] adc_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  ld_cnt_q;
    logic [CNT_W-1:0]  beat_q;
    logic [DEC_W-1:0]  decim_q;
    logic [1:0]        mode_q;
    logic [OUT_W-1:0]  data_q;
    logic              valid_q;
    logic              last_q;
    logic              done_q;
    logic              busy_q;
    logic              ovr_q;

    logic              start;
    logic              run;
    logic              slot;
    logic              hs;
    logic              load;
    logic              drop;
    logic              load_last;
    logic [DATA_W-1:0] sample;

    assign start = (state_q == ST_IDLE) && i_ADC_Work;
    // Dropping Work in RUN takes effect in the same cycle: no sample is taken then.
    assign run   = (state_q == ST_RUN) && i_ADC_Work;

    pl_adc_decimator #(
        .DEC_W (DEC_W)
    ) u_decim (
        .clk_i   (i_CMOS_Clk),
        .rst_ni  (i_Rst_n),
        .clear_i (start),
        .run_i   (run),
        .decim_i (decim_q),
        .slot_o  (slot)
    );

    assign hs        = valid_q && i_Ready;
    // The output register is free if empty or being emptied this cycle.
    assign load      = slot && (!valid_q || i_Ready);
    assign drop      = slot && valid_q && !i_Ready;
    assign load_last = load && (ld_cnt_q == (num_q - 1'b1));

    // The counter pattern tags each sample with the index it will be delivered
    // as; dropped samples never consume an index, so the pattern stays gap-free.
    always_comb begin
        sample = adc_q;
        case (mode_q)
            MODE_LIVE, MODE_LIVE_ALT: sample = adc_q;
            MODE_COUNT:               sample = ld_cnt_q[DATA_W-1:0];
            MODE_FIXED:               sample = FIXED_PATTERN;
        endcase
    end

    always_ff @(posedge i_CMOS_Clk) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            adc_q    <= '0;
            num_q    <= '0;
            ld_cnt_q <= '0;
            beat_q   <= '0;
            decim_q  <= '0;
            mode_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            adc_q <= i_CMOS_Data;

            if (hs) begin
                beat_q <= beat_q + 1'b1;
            end

            if (load) begin
                data_q   <= OUT_W'(sample);
                valid_q  <= 1'b1;
                last_q   <= load_last;
                ld_cnt_q <= ld_cnt_q + 1'b1;
            end else if (hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end

            if (drop) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_ADC_Work) begin
                        num_q    <= i_Num_Samples;
                        decim_q  <= i_Decim;
                        mode_q   <= i_Mode;
                        beat_q   <= '0;
                        ld_cnt_q <= '0;
                        ovr_q    <= 1'b0;
                        if (i_Num_Samples == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!i_ADC_Work || load_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!valid_q || hs) begin
                        busy_q <= 1'b0;
                        // A full load count means the frame completed; anything
                        // less means we got here through an abort.
                        if (ld_cnt_q == num_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_ADC_Work) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Data       = data_q;
    assign o_Valid      = valid_q;
    assign o_Last       = last_q;
    assign o_ADC_Done   = done_q;
    assign o_Busy       = busy_q;
    assign o_Overrun    = ovr_q;
    assign o_Beat_Count = beat_q;

endmodule

// File: tb/tb_pl_adc_stream_capture.sv
// tb/tb_pl_adc_stream_capture.sv - scoreboard bench for pl_adc_stream_capture

module tb_pl_adc_stream_capture;

    localparam int DATA_W = 12;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 20;
    localparam int DEC_W  = 8;
    localparam logic [15:0] FIXED = 16'h0929;

    logic              clk = 1'b0;
    logic              i_Rst_n;
    logic [DATA_W-1:0] i_CMOS_Data;
    logic              i_ADC_Work;
    logic [1:0]        i_Mode;
    logic [CNT_W-1:0]  i_Num_Samples;
    logic [DEC_W-1:0]  i_Decim;
    logic [OUT_W-1:0]  o_Data;
    logic              o_Valid;
    logic              i_Ready;
    logic              o_Last;
    logic              o_ADC_Done;
    logic              o_Busy;
    logic              o_Overrun;
    logic [CNT_W-1:0]  o_Beat_Count;

    always #5 clk = ~clk;

    pl_adc_stream_capture dut (
        .i_CMOS_Clk    (clk),
        .i_Rst_n       (i_Rst_n),
        .i_CMOS_Data   (i_CMOS_Data),
        .i_ADC_Work    (i_ADC_Work),
        .i_Mode        (i_Mode),
        .i_Num_Samples (i_Num_Samples),
        .i_Decim       (i_Decim),
        .o_Data        (o_Data),
        .o_Valid       (o_Valid),
        .i_Ready       (i_Ready),
        .o_Last        (o_Last),
        .o_ADC_Done    (o_ADC_Done),
        .o_Busy        (o_Busy),
        .o_Overrun     (o_Overrun),
        .o_Beat_Count  (o_Beat_Count)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    tick     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin value held between edge t and edge t+1.
    function automatic logic [11:0] live_val(input int t);
        return 12'(t * 37 + 5);
    endfunction

    always @(posedge clk) begin
        tick = tick + 1;
        #1 i_CMOS_Data = live_val(tick);
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        beat_t b;
        if (!i_Rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(o_Valid), 32'd1);
                check("hold_data", 32'(o_Data), 32'(prev_data));
                check("hold_last", 32'(o_Last), 32'(prev_last));
            end
            if (o_Valid && i_Ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(o_Data), 32'(b.data));
                    check("beat_last", 32'(o_Last), 32'(b.last));
                end
            end
            prev_hold = o_Valid && !i_Ready;
            prev_data = o_Data;
            prev_last = o_Last;
        end
    end

    function automatic logic ready_for(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            2:       return !(cyc >= 4 && cyc < 14);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(o_Data), 32'd0);
        check({tag, "_valid"}, 32'(o_Valid), 32'd0);
        check({tag, "_last"}, 32'(o_Last), 32'd0);
        check({tag, "_done"}, 32'(o_ADC_Done), 32'd0);
        check({tag, "_busy"}, 32'(o_Busy), 32'd0);
        check({tag, "_ovr"}, 32'(o_Overrun), 32'd0);
        check({tag, "_count"}, 32'(o_Beat_Count), 32'd0);
    endtask

    task automatic run_frame(input int mode, input int num, input int dec, input int rmode,
                             input bit chk_ovr, input bit exp_ovr);
        int    s;
        bit    done;
        beat_t b;
        @(posedge clk); #1;
        s             = tick;
        i_Mode        = 2'(mode);
        i_Num_Samples = CNT_W'(num);
        i_Decim       = DEC_W'(dec);
        i_ADC_Work    = 1'b1;
        i_Ready       = ready_for(rmode, 0);
        for (int k = 0; k < num; k++) begin
            if (mode == 1)      b.data = 16'(k);
            else if (mode == 2) b.data = FIXED;
            else                b.data = 16'(live_val(s + k * (dec + 1)));
            b.last = (k == num - 1);
            exp_q.push_back(b);
        end
        done = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (o_ADC_Done) begin
                done = 1'b1;
                break;
            end
            i_Ready = ready_for(rmode, cyc);
        end
        check("frame_done", 32'(done), 32'd1);
        check("frame_count", 32'(o_Beat_Count), 32'(num));
        check("frame_sb_empty", 32'(exp_q.size()), 32'd0);
        check("frame_valid_off", 32'(o_Valid), 32'd0);
        check("frame_busy_off", 32'(o_Busy), 32'd0);
        if (chk_ovr) check("frame_overrun", 32'(o_Overrun), 32'(exp_ovr));
        exp_q.delete();
        @(posedge clk); #1;
        check("done_held", 32'(o_ADC_Done), 32'd1);
        i_ADC_Work = 1'b0;
        @(posedge clk); #1;
        check("done_cleared", 32'(o_ADC_Done), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        beat_t b;
        bit    ok;
        i_Rst_n       = 1'b0;
        i_ADC_Work    = 1'b0;
        i_Mode        = '0;
        i_Num_Samples = '0;
        i_Decim       = '0;
        i_Ready       = 1'b0;
        i_CMOS_Data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_Rst_n = 1'b1;

        // Counter pattern, back-to-back beats.
        run_frame(1, 8, 0, 0, 1'b1, 1'b0);
        // Live data with decimation by 4.
        run_frame(0, 4, 3, 0, 1'b1, 1'b0);
        // Fixed pattern with a 10-cycle stall: overrun but still 5 beats.
        run_frame(2, 5, 0, 2, 1'b1, 1'b1);

        // Zero-length frame goes straight to DONE.
        @(posedge clk); #1;
        i_Num_Samples = '0;
        i_Mode        = 2'd1;
        i_Ready       = 1'b1;
        i_ADC_Work    = 1'b1;
        @(posedge clk); #1;
        check("num0_done", 32'(o_ADC_Done), 32'd1);
        check("num0_busy", 32'(o_Busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("num0_novalid", 32'(o_Valid), 32'd0);
            check("num0_no_restart", 32'(o_ADC_Done), 32'd1);
        end
        i_ADC_Work = 1'b0;
        @(posedge clk); #1;
        check("num0_done_clr", 32'(o_ADC_Done), 32'd0);

        // Abort after 3 delivered beats: the outstanding beat still goes out.
        @(posedge clk); #1;
        i_Mode        = 2'd1;
        i_Num_Samples = CNT_W'(100);
        i_Decim       = '0;
        i_Ready       = 1'b1;
        i_ADC_Work    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b.data = 16'(k);
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (o_Beat_Count == CNT_W'(3)) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach3", 32'(ok), 32'd1);
        i_ADC_Work = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_idle", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("abort_count", 32'(o_Beat_Count), 32'd4);
        check("abort_no_done", 32'(o_ADC_Done), 32'd0);
        check("abort_valid", 32'(o_Valid), 32'd0);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset mid-frame while a beat is stalled.
        @(posedge clk); #1;
        i_Mode        = 2'd1;
        i_Num_Samples = CNT_W'(50);
        i_Ready       = 1'b0;
        i_ADC_Work    = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(o_Valid), 32'd1);
        i_Rst_n    = 1'b0;
        i_ADC_Work = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        i_Rst_n = 1'b1;
        run_frame(1, 4, 0, 0, 1'b1, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            int mode, num, dec, rmode;
            mode  = $urandom_range(0, 3);
            num   = $urandom_range(1, 12);
            dec   = $urandom_range(0, 3);
            rmode = (mode == 0 || mode == 3) ? 0 : 1;
            run_frame(mode, num, dec, rmode, rmode == 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
